geofence_ngon: RTL and testbench

Parametrised point-in-convex-polygon engine, next generation of the univ-cell geofence. It accepts one test point followed by NV polygon vertices in arbitrary order over a valid/ready stream. It angularly sorts the vertices around vertex 0 and checks the test point against every edge with one shared cross-product unit. It returns a single inside/outside verdict over a valid/ready result port and sits between the coordinate stream source and the alarm/logging logic.

---
 rtl/geofence_pkg.sv | 34 +++
 rtl/geofence_cross.sv | 37 +++
 rtl/geofence_ngon.sv | 191 +++++++++++++++++++
 tb/tb_geofence_ngon.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/geofence_pkg.sv
// Shared types, arithmetic widths and helper functions for the point-in-convex-polygon engine.
package geofence_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SORT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  localparam int CW_DEF = 10;
  localparam int DIFF_W = CW_DEF + 1;
  localparam int PROD_W = 2 * CW_DEF + 2;
  localparam int CROSS_W = 2 * CW_DEF + 3;

  function automatic int diff_w(input int cw);
    return cw + 1;
  endfunction

  function automatic int prod_w(input int cw);
    return 2 * cw + 2;
  endfunction

  function automatic int cross_w(input int cw);
    return 2 * cw + 3;
  endfunction

  // Number of (i,j) pairs visited by the selection sort anchored on vertex 0.
  function automatic int sort_cycles(input int nv);
    return ((nv - 1) * (nv - 2)) / 2;
  endfunction

endpackage

// File: rtl/geofence_cross.sv
// Combinational signed cross product (p1-ref) x (p2-ref) on unsigned CW-bit coordinates.
module geofence_cross
  import geofence_pkg::*;
#(
  parameter int CW = 10
) (
  input  logic [CW-1:0]                 i_ref_x,
  input  logic [CW-1:0]                 i_ref_y,
  input  logic [CW-1:0]                 i_p1_x,
  input  logic [CW-1:0]                 i_p1_y,
  input  logic [CW-1:0]                 i_p2_x,
  input  logic [CW-1:0]                 i_p2_y,
  output logic signed [cross_w(CW)-1:0] o_cross
);

  localparam int DW = diff_w(CW);
  localparam int PW = prod_w(CW);
  localparam int XW = cross_w(CW);

  logic signed [DW-1:0] w_ax;
  logic signed [DW-1:0] w_ay;
  logic signed [DW-1:0] w_bx;
  logic signed [DW-1:0] w_by;
  logic signed [PW-1:0] w_p0;
  logic signed [PW-1:0] w_p1;

  assign w_ax = $signed({1'b0, i_p1_x}) - $signed({1'b0, i_ref_x});
  assign w_ay = $signed({1'b0, i_p1_y}) - $signed({1'b0, i_ref_y});
  assign w_bx = $signed({1'b0, i_p2_x}) - $signed({1'b0, i_ref_x});
  assign w_by = $signed({1'b0, i_p2_y}) - $signed({1'b0, i_ref_y});

  // Each product of two CW+1-bit signed values fits PW bits exactly; the difference needs one more.
  assign w_p0 = PW'(w_ax) * PW'(w_by);
  assign w_p1 = PW'(w_bx) * PW'(w_ay);
  assign o_cross = XW'(w_p0) - XW'(w_p1);

endmodule

// File: rtl/geofence_ngon.sv
// Point-in-convex-polygon engine: loads a test point and NV vertices, sorts them CCW about
// vertex 0, then tests the point against each edge with one time-shared cross-product unit.
module geofence_ngon
  import geofence_pkg::*;
#(
  parameter int NV             = 6,
  parameter int CW             = 10,
  parameter int ON_EDGE_INSIDE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_x,
  input  logic [CW-1:0] in_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          is_inside
);

  localparam int IW = $clog2(NV);
  localparam int XW = cross_w(CW);
  localparam logic [IW-1:0] K_LAST = IW'(NV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NV - 2);
  localparam logic ON_EDGE_OK = (ON_EDGE_INSIDE != 0);

  state_e r_state;
  state_e w_next;

  logic [IW-1:0] r_i;
  logic [IW-1:0] r_j;
  logic [IW-1:0] r_k;
  logic [IW-1:0] w_k_next;
  logic [CW-1:0] r_vx [NV];
  logic [CW-1:0] r_vy [NV];
  logic [CW-1:0] r_tx;
  logic [CW-1:0] r_ty;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_is_inside;

  logic [CW-1:0] w_ref_x;
  logic [CW-1:0] w_ref_y;
  logic [CW-1:0] w_p1_x;
  logic [CW-1:0] w_p1_y;
  logic [CW-1:0] w_p2_x;
  logic [CW-1:0] w_p2_y;
  logic signed [XW-1:0] w_cross;
  logic          w_edge_fail;
  logic          w_in_fire;
  logic          w_out_fire;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign is_inside = r_is_inside;

  assign w_in_fire   = in_valid && r_in_ready;
  assign w_out_fire  = r_out_valid && out_ready;
  assign w_k_next    = (r_k == K_LAST) ? '0 : r_k + IW'(1);
  assign w_edge_fail = w_cross[XW-1] || ((w_cross == '0) && !ON_EDGE_OK);

  // Operand mux: SORT orders v[i],v[j] about v[0]; CHECK tests the point against edge k.
  always_comb begin
    w_ref_x = r_vx[0];
    w_ref_y = r_vy[0];
    w_p1_x  = r_vx[r_i];
    w_p1_y  = r_vy[r_i];
    w_p2_x  = r_vx[r_j];
    w_p2_y  = r_vy[r_j];
    if (r_state == ST_CHECK) begin
      w_ref_x = r_vx[r_k];
      w_ref_y = r_vy[r_k];
      w_p1_x  = r_vx[w_k_next];
      w_p1_y  = r_vy[w_k_next];
      w_p2_x  = r_tx;
      w_p2_y  = r_ty;
    end else begin
      w_ref_x = r_vx[0];
      w_ref_y = r_vy[0];
    end
  end

  geofence_cross #(.CW(CW)) u_cross (
    .i_ref_x (w_ref_x),
    .i_ref_y (w_ref_y),
    .i_p1_x  (w_p1_x),
    .i_p1_y  (w_p1_y),
    .i_p2_x  (w_p2_x),
    .i_p2_y  (w_p2_y),
    .o_cross (w_cross)
  );

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_in_fire) w_next = ST_LOAD;
        else           w_next = ST_IDLE;
      end
      ST_LOAD: begin
        if (w_in_fire && (r_k == K_LAST)) w_next = ST_SORT;
        else                              w_next = ST_LOAD;
      end
      ST_SORT: begin
        if ((r_i == I_LAST) && (r_j == K_LAST)) w_next = ST_CHECK;
        else                                    w_next = ST_SORT;
      end
      ST_CHECK: begin
        if (w_edge_fail || (r_k == K_LAST)) w_next = ST_OUT;
        else                                w_next = ST_CHECK;
      end
      ST_OUT: begin
        if (w_out_fire) w_next = ST_IDLE;
        else            w_next = ST_OUT;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Datapath: point/vertex file with sort swap, counters and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx <= '0;
      r_ty <= '0;
      for (int n = 0; n < NV; n++) begin
        r_vx[n] <= '0;
        r_vy[n] <= '0;
      end
      r_i         <= IW'(1);
      r_j         <= IW'(2);
      r_k         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_is_inside <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == ST_IDLE) || (w_next == ST_LOAD);
      r_out_valid <= (w_next == ST_OUT);
      case (r_state)
        ST_IDLE: begin
          if (w_in_fire) begin
            r_tx <= in_x;
            r_ty <= in_y;
            r_k  <= '0;
          end
        end
        ST_LOAD: begin
          if (w_in_fire) begin
            r_vx[r_k] <= in_x;
            r_vy[r_k] <= in_y;
            r_k       <= w_k_next;
            r_i       <= IW'(1);
            r_j       <= IW'(2);
          end
        end
        ST_SORT: begin
          if (w_cross[XW-1]) begin
            r_vx[r_i] <= r_vx[r_j];
            r_vy[r_i] <= r_vy[r_j];
            r_vx[r_j] <= r_vx[r_i];
            r_vy[r_j] <= r_vy[r_i];
          end
          if (r_j == K_LAST) begin
            r_i <= r_i + IW'(1);
            r_j <= r_i + IW'(2);
          end else begin
            r_j <= r_j + IW'(1);
          end
        end
        ST_CHECK: begin
          if (w_edge_fail)          r_is_inside <= 1'b0;
          else if (r_k == K_LAST)   r_is_inside <= 1'b1;
          r_k <= w_k_next;
        end
        ST_OUT: begin
          if (w_out_fire) r_is_inside <= 1'b0;
        end
        default: begin
          r_k <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_geofence_ngon.sv
// Scoreboard bench for geofence_ngon: four instances (hexagon with both on-edge rules,
// triangle, square); a driver pushes hand-computed verdicts/latencies, a monitor pops and compares.
module tb_geofence_ngon;

  typedef struct {
    int  dut;
    int  verdict;
    int  lat;
    time t_acc;
  } exp_t;

  logic       clk;
  logic       rst_n     [4];
  logic       in_valid  [4];
  logic       in_ready  [4];
  logic [9:0] in_x      [4];
  logic [9:0] in_y      [4];
  logic       out_valid [4];
  logic       out_ready [4];
  logic       is_inside [4];

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb [$];
  exp_t mon_e;
  logic was_valid [4];
  logic was_fire  [4];
  logic held      [4];

  // Hexagon fed as D,A,F,B,E,C; sorted CCW about D it becomes D,E,F,A,B,C.
  int hx [8] = '{400, 600, 550, 550, 450, 450, 0, 0};
  int hy [8] = '{500, 500, 413, 587, 413, 587, 0, 0};
  int tx [8] = '{0, 1023, 0, 0, 0, 0, 0, 0};
  int ty [8] = '{0, 0, 1023, 0, 0, 0, 0, 0};
  int sx [8] = '{0, 1023, 0, 1023, 0, 0, 0, 0};
  int sy [8] = '{0, 1023, 1023, 0, 0, 0, 0, 0};

  geofence_ngon #(.NV(6), .CW(10), .ON_EDGE_INSIDE(0)) u_hex0 (
    .clk(clk), .reset(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_x(in_x[0]), .in_y(in_y[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .is_inside(is_inside[0]));
  geofence_ngon #(.NV(6), .CW(10), .ON_EDGE_INSIDE(1)) u_hex1 (
    .clk(clk), .reset(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_x(in_x[1]), .in_y(in_y[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .is_inside(is_inside[1]));
  geofence_ngon #(.NV(3), .CW(10), .ON_EDGE_INSIDE(0)) u_tri (
    .clk(clk), .reset(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_x(in_x[2]), .in_y(in_y[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .is_inside(is_inside[2]));
  geofence_ngon #(.NV(4), .CW(10), .ON_EDGE_INSIDE(0)) u_sq (
    .clk(clk), .reset(rst_n[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_x(in_x[3]), .in_y(in_y[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .is_inside(is_inside[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input int d, input string nm, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_err++;
      $display("FAIL dut%0d %s actual=%0d expected=%0d t=%0t", d, nm, act, want, $time);
    end
  endtask

  // Monitor: new verdict pops the scoreboard; a held verdict must not move.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (rst_n[d] && out_valid[d]) begin
        if (!was_valid[d] || was_fire[d]) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL dut%0d unexpected_verdict actual=%0d expected=none", d, is_inside[d]);
          end else begin
            mon_e = sb.pop_front();
            chk(d, "dut_id", d, mon_e.dut);
            chk(d, "verdict", int'(is_inside[d]), mon_e.verdict);
            chk(d, "latency", int'(($time - 5 - mon_e.t_acc) / 10), mon_e.lat);
          end
        end else begin
          chk(d, "held_verdict", int'(is_inside[d]), int'(held[d]));
        end
        chk(d, "in_ready_while_pending", int'(in_ready[d]), 0);
        held[d] = is_inside[d];
      end
      was_valid[d] = rst_n[d] && out_valid[d];
      was_fire[d]  = out_valid[d] && out_ready[d];
    end
  end

  // Offer one beat (called #1 after a rising edge); returns the accepting edge time.
  task automatic beat(input int d, input int x, input int y, output time t);
    int n = 0;
    in_x[d] = 10'(x);
    in_y[d] = 10'(y);
    in_valid[d] = 1'b1;
    while (!in_ready[d] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk(d, "beat_accept_timeout", int'(in_ready[d]), 1);
    @(posedge clk);
    t = $time;
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic send(input int d, input int nv, input int px, input int py,
                      input int vx [8], input int vy [8], output time t, input bit gaps);
    beat(d, px, py, t);
    for (int n = 0; n < nv; n++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      beat(d, vx[n], vy[n], t);
    end
  endtask

  task automatic txn(input int d, input int nv, input int px, input int py,
                     input int vx [8], input int vy [8], input int want, input int lat,
                     input bit gaps);
    exp_t e;
    time  t;
    send(d, nv, px, py, vx, vy, t, gaps);
    e.dut = d; e.verdict = want; e.lat = lat; e.t_acc = t;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) chk(0, "drain_timeout", sb.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic wait_valid(input int d);
    int n = 0;
    while (!out_valid[d] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(d, "out_valid_seen", int'(out_valid[d]), 1);
  endtask

  initial begin
    time t_dummy;
    for (int d = 0; d < 4; d++) begin
      rst_n[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b1;
      in_x[d] = 10'd0; in_y[d] = 10'd0;
      was_valid[d] = 1'b0; was_fire[d] = 1'b0; held[d] = 1'b0;
    end
    #12;
    for (int d = 0; d < 4; d++) begin
      chk(d, "rst_in_ready", int'(in_ready[d]), 0);
      chk(d, "rst_out_valid", int'(out_valid[d]), 0);
      chk(d, "rst_is_inside", int'(is_inside[d]), 0);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) rst_n[d] = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) chk(d, "post_rst_in_ready", int'(in_ready[d]), 1);

    // Hexagon: inside, early exit at edge 2, on-edge at edge 4; back-to-back transactions.
    txn(0, 6, 500, 500, hx, hy, 1, 16, 1'b0);
    txn(0, 6, 700, 500, hx, hy, 0, 13, 1'b0);
    txn(0, 6, 500, 587, hx, hy, 0, 15, 1'b0);
    drain();
    txn(1, 6, 500, 587, hx, hy, 1, 16, 1'b0);
    txn(1, 6, 700, 500, hx, hy, 0, 13, 1'b0);
    drain();

    // Random in_valid gaps during LOAD.
    txn(0, 6, 500, 500, hx, hy, 1, 16, 1'b1);
    txn(0, 6, 700, 500, hx, hy, 0, 13, 1'b1);
    drain();

    // Output backpressure for 5 cycles.
    out_ready[0] = 1'b0;
    txn(0, 6, 500, 500, hx, hy, 1, 16, 1'b0);
    wait_valid(0);
    repeat (5) begin
      @(posedge clk); #1;
      chk(0, "bp_out_valid_held", int'(out_valid[0]), 1);
      chk(0, "bp_in_ready_low", int'(in_ready[0]), 0);
    end
    out_ready[0] = 1'b1;
    drain();

    // Reset while a verdict is pending.
    out_ready[0] = 1'b0;
    txn(0, 6, 500, 500, hx, hy, 1, 16, 1'b0);
    wait_valid(0);
    @(posedge clk); #1;
    chk(0, "pre_rst_is_inside", int'(is_inside[0]), 1);
    rst_n[0] = 1'b0;
    #1;
    chk(0, "rst_out_out_valid", int'(out_valid[0]), 0);
    chk(0, "rst_out_is_inside", int'(is_inside[0]), 0);
    chk(0, "rst_out_in_ready", int'(in_ready[0]), 0);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    @(posedge clk); #1;
    chk(0, "rst_out_recover_in_ready", int'(in_ready[0]), 1);
    txn(0, 6, 700, 500, hx, hy, 0, 13, 1'b0);
    drain();

    // Triangle: reset during SORT aborts, then a full transaction.
    send(2, 3, 100, 100, tx, ty, t_dummy, 1'b0);
    rst_n[2] = 1'b0;
    #1;
    chk(2, "rst_sort_out_valid", int'(out_valid[2]), 0);
    chk(2, "rst_sort_is_inside", int'(is_inside[2]), 0);
    chk(2, "rst_sort_in_ready", int'(in_ready[2]), 0);
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    chk(2, "rst_sort_in_ready_before_edge", int'(in_ready[2]), 0);
    @(posedge clk); #1;
    chk(2, "rst_sort_in_ready_after_edge", int'(in_ready[2]), 1);
    txn(2, 3, 100, 100, tx, ty, 1, 4, 1'b0);
    drain();

    // Extreme square: vertex point fails on the edge rule, centre is inside.
    txn(3, 4, 1023, 1023, sx, sy, 0, 5, 1'b0);
    txn(3, 4, 512, 512, sx, sy, 1, 7, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
